// File: rtl/video_ports_pkg.sv
// Shared constants and helpers for the video parameter port block.
// Address map, reset values and packed-byte compositions.
package video_ports_pkg;

  localparam logic [5:0] A_VCONF   = 6'h00;
  localparam logic [5:0] A_VPAGE   = 6'h01;
  localparam logic [5:0] A_GX_LO   = 6'h02;
  localparam logic [5:0] A_GX_HI   = 6'h03;
  localparam logic [5:0] A_GY_LO   = 6'h04;
  localparam logic [5:0] A_GY_HI   = 6'h05;
  localparam logic [5:0] A_TSCONF  = 6'h06;
  localparam logic [5:0] A_PALSEL  = 6'h07;
  localparam logic [5:0] A_TMPAGE  = 6'h08;
  localparam logic [5:0] A_SGPAGE  = 6'h09;
  localparam logic [5:0] A_HINT    = 6'h0A;
  localparam logic [5:0] A_VINT_LO = 6'h0B;
  localparam logic [5:0] A_VINT_HI = 6'h0C;
  localparam logic [5:0] A_CTRL    = 6'h0D;
  localparam logic [5:0] A_ZBORDER = 6'h0E;
  localparam logic [5:0] A_BORDER  = 6'h0F;
  localparam logic [5:0] A_ZVPAGE  = 6'h30;
  localparam logic [5:0] A_LYR     = 6'h10;

  localparam int LYR_STRIDE = 8;

  localparam logic [2:0] L_X_LO  = 3'd0;
  localparam logic [2:0] L_X_HI  = 3'd1;
  localparam logic [2:0] L_Y_LO  = 3'd2;
  localparam logic [2:0] L_Y_HI  = 3'd3;
  localparam logic [2:0] L_GPAGE = 3'd4;

  localparam logic [7:0] RST_VPAGE  = 8'h05;
  localparam logic [7:0] RST_PALSEL = 8'h0F;
  localparam logic [7:0] RST_HINT   = 8'h01;

  function automatic logic [7:0] zvpage_f(
    input logic [7:0] d
  );
    return {6'b000001, d[3], 1'b1};
  endfunction

  function automatic logic [7:0] zborder_f(
    input logic [7:0] pal,
    input logic [7:0] d
  );
    return {pal[3:0], 1'b0, d[2:0]};
  endfunction

endpackage

// File: rtl/video_offs_reg.sv
// One scroll offset: lo latch, optional shadow, active value.
// Hi write assembles the full word so updates are atomic.
module video_offs_reg
  import video_ports_pkg::*;
#(
  parameter int OFFS_W   = 9,
  parameter bit SHADOWED = 1'b1
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic [7:0]        d,
  input  logic              lo_we,
  input  logic              hi_we,
  input  logic              commit,
  output logic [OFFS_W-1:0] q
);

  logic [7:0]        lo;
  logic [OFFS_W-1:0] val;
  logic              unused_d;

  assign val      = {d[OFFS_W-9:0], lo};
  assign unused_d = ^d;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      lo <= '0;
    end else if (lo_we) begin
      lo <= d;
    end
  end

  if (SHADOWED) begin : g_sh
    logic [OFFS_W-1:0] sh;

    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        sh <= '0;
        q  <= '0;
      end else begin
        if (hi_we)  sh <= val;
        if (commit) q  <= sh;
      end
    end
  end else begin : g_im
    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        q <= '0;
      end else if (hi_we) begin
        q <= val;
      end
    end
  end

endmodule

// File: rtl/video_ports_gen.sv
// Video parameter port block: byte writes into shadow/active regs,
// line/frame commit, tile layers and vint line stepper.
module video_ports_gen
  import video_ports_pkg::*;
#(
  parameter int NUM_TLAYERS = 2,
  parameter int OFFS_W      = 9,
  parameter int INT_LINES   = 320
) (
  input  logic                          clk,
  input  logic                          res_n,
  input  logic [7:0]                    d,
  input  logic [5:0]                    addr,
  input  logic                          wr_stb,
  input  logic                          int_start,
  input  logic                          line_start_s,
  output logic [7:0]                    border,
  output logic [7:0]                    vpage,
  output logic [7:0]                    vconf,
  output logic [7:0]                    palsel,
  output logic [7:0]                    tsconf,
  output logic [7:0]                    tmpage,
  output logic [7:0]                    sgpage,
  output logic [7:0]                    hint_beg,
  output logic [OFFS_W-1:0]             gx_offs,
  output logic [OFFS_W-1:0]             gy_offs,
  output logic [NUM_TLAYERS*OFFS_W-1:0] tx_offs,
  output logic [NUM_TLAYERS*OFFS_W-1:0] ty_offs,
  output logic [NUM_TLAYERS*8-1:0]      tgpage,
  output logic [8:0]                    vint_beg,
  output logic                          pending
);

  localparam logic [6:0] LYR_END =
    7'(int'(A_LYR) + LYR_STRIDE * NUM_TLAYERS);

  logic [7:0] vconf_sh, vpage_sh, palsel_sh;
  logic       frame_sync;
  logic [3:0] vint_inc;
  logic       commit;

  logic we_vconf, we_vpage, we_gx_lo, we_gx_hi;
  logic we_gy_lo, we_gy_hi, we_tsconf, we_palsel;
  logic we_tmpage, we_sgpage, we_hint, we_vint_lo;
  logic we_vint_hi, we_ctrl, we_zborder, we_border;
  logic we_zvpage, we_lyr;

  logic [5:0] lyr_off;
  logic [2:0] lyr_k, lyr_reg;
  logic       lyr_hit, lyr_lg;
  logic       lg_wr;

  logic [9:0] vsum;
  logic [8:0] vint_next;

  assign commit  = frame_sync ? int_start : line_start_s;
  assign lyr_off = addr - A_LYR;
  assign lyr_k   = lyr_off[5:3];
  assign lyr_reg = lyr_off[2:0];
  assign lyr_hit = (addr >= A_LYR) && ({1'b0, addr} < LYR_END);

  always_comb begin
    we_vconf   = 1'b0;
    we_vpage   = 1'b0;
    we_gx_lo   = 1'b0;
    we_gx_hi   = 1'b0;
    we_gy_lo   = 1'b0;
    we_gy_hi   = 1'b0;
    we_tsconf  = 1'b0;
    we_palsel  = 1'b0;
    we_tmpage  = 1'b0;
    we_sgpage  = 1'b0;
    we_hint    = 1'b0;
    we_vint_lo = 1'b0;
    we_vint_hi = 1'b0;
    we_ctrl    = 1'b0;
    we_zborder = 1'b0;
    we_border  = 1'b0;
    we_zvpage  = 1'b0;
    we_lyr     = 1'b0;
    if (wr_stb) begin
      unique case (1'b1)
        addr == A_VCONF:   we_vconf   = 1'b1;
        addr == A_VPAGE:   we_vpage   = 1'b1;
        addr == A_GX_LO:   we_gx_lo   = 1'b1;
        addr == A_GX_HI:   we_gx_hi   = 1'b1;
        addr == A_GY_LO:   we_gy_lo   = 1'b1;
        addr == A_GY_HI:   we_gy_hi   = 1'b1;
        addr == A_TSCONF:  we_tsconf  = 1'b1;
        addr == A_PALSEL:  we_palsel  = 1'b1;
        addr == A_TMPAGE:  we_tmpage  = 1'b1;
        addr == A_SGPAGE:  we_sgpage  = 1'b1;
        addr == A_HINT:    we_hint    = 1'b1;
        addr == A_VINT_LO: we_vint_lo = 1'b1;
        addr == A_VINT_HI: we_vint_hi = 1'b1;
        addr == A_CTRL:    we_ctrl    = 1'b1;
        addr == A_ZBORDER: we_zborder = 1'b1;
        addr == A_BORDER:  we_border  = 1'b1;
        addr == A_ZVPAGE:  we_zvpage  = 1'b1;
        lyr_hit:           we_lyr     = 1'b1;
        default: ;
      endcase
    end
  end

  assign lyr_lg = we_lyr && (lyr_reg == L_X_LO ||
                             lyr_reg == L_X_HI ||
                             lyr_reg == L_GPAGE);

  assign lg_wr = we_vconf | we_vpage | we_gx_lo |
                 we_gx_hi | we_palsel | lyr_lg;

  // 10-bit sum so an out-of-range written start still wraps once
  assign vsum      = {1'b0, vint_beg} + {6'b0, vint_inc};
  assign vint_next = (vsum >= 10'(INT_LINES))
                   ? 9'(vsum - 10'(INT_LINES))
                   : vsum[8:0];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      border     <= '0;
      tsconf     <= '0;
      tmpage     <= '0;
      sgpage     <= '0;
      hint_beg   <= RST_HINT;
      vconf_sh   <= '0;
      vconf      <= '0;
      vpage_sh   <= RST_VPAGE;
      vpage      <= RST_VPAGE;
      palsel_sh  <= RST_PALSEL;
      palsel     <= RST_PALSEL;
      frame_sync <= 1'b0;
      vint_inc   <= '0;
      vint_beg   <= '0;
      pending    <= 1'b0;
    end else begin
      if (we_border)  border <= d;
      if (we_zborder) border <= zborder_f(palsel, d);
      if (we_tsconf)  tsconf   <= d;
      if (we_tmpage)  tmpage   <= d;
      if (we_sgpage)  sgpage   <= d;
      if (we_hint)    hint_beg <= d;
      if (we_ctrl)    frame_sync <= d[0];

      if (commit) begin
        vconf  <= vconf_sh;
        palsel <= palsel_sh;
        vpage  <= vpage_sh;
      end
      if (we_vconf)  vconf_sh  <= d;
      if (we_palsel) palsel_sh <= d;
      if (we_vpage)  vpage_sh  <= d;
      if (we_zvpage) begin
        vpage_sh <= zvpage_f(d);
        vpage    <= zvpage_f(d);
      end

      if (we_vint_lo) vint_beg[7:0] <= d;
      if (we_vint_hi) begin
        vint_beg[8] <= d[0];
        vint_inc    <= d[7:4];
      end
      if (int_start && !we_vint_lo && !we_vint_hi)
        vint_beg <= vint_next;

      if (lg_wr)       pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end

  video_offs_reg #(
    .OFFS_W  (OFFS_W),
    .SHADOWED(1'b1)
  ) u_gx (
    .clk   (clk),
    .res_n (res_n),
    .d     (d),
    .lo_we (we_gx_lo),
    .hi_we (we_gx_hi),
    .commit(commit),
    .q     (gx_offs)
  );

  video_offs_reg #(
    .OFFS_W  (OFFS_W),
    .SHADOWED(1'b0)
  ) u_gy (
    .clk   (clk),
    .res_n (res_n),
    .d     (d),
    .lo_we (we_gy_lo),
    .hi_we (we_gy_hi),
    .commit(commit),
    .q     (gy_offs)
  );

  for (genvar k = 0; k < NUM_TLAYERS; k++) begin : g_lyr
    logic       sel;
    logic [7:0] gp_sh, gp;

    assign sel = we_lyr && (lyr_k == 3'(k));

    video_offs_reg #(
      .OFFS_W  (OFFS_W),
      .SHADOWED(1'b1)
    ) u_x (
      .clk   (clk),
      .res_n (res_n),
      .d     (d),
      .lo_we (sel && lyr_reg == L_X_LO),
      .hi_we (sel && lyr_reg == L_X_HI),
      .commit(commit),
      .q     (tx_offs[k*OFFS_W +: OFFS_W])
    );

    video_offs_reg #(
      .OFFS_W  (OFFS_W),
      .SHADOWED(1'b0)
    ) u_y (
      .clk   (clk),
      .res_n (res_n),
      .d     (d),
      .lo_we (sel && lyr_reg == L_Y_LO),
      .hi_we (sel && lyr_reg == L_Y_HI),
      .commit(commit),
      .q     (ty_offs[k*OFFS_W +: OFFS_W])
    );

    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        gp_sh <= '0;
        gp    <= '0;
      end else begin
        if (commit) gp <= gp_sh;
        if (sel && lyr_reg == L_GPAGE) gp_sh <= d;
      end
    end

    assign tgpage[k*8 +: 8] = gp;
  end

endmodule
